// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state, access-size and counter definitions for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] DIGIT_B = 2'b00;
  localparam logic [1:0] DIGIT_H = 2'b01;
  localparam logic [1:0] DIGIT_W = 2'b10;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian byte-lane steering for stores and right-justification for loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  digit,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [31:0] sh;
  logic [31:0] keep;
  assign sh = rword >> {lane, 3'b000};
  always_comb begin
    mask = digit == DIGIT_B ? 4'b0001 << lane :
           digit == DIGIT_H ? 4'b0011 << {lane[1], 1'b0} :
           digit == DIGIT_W ? 4'b1111 : 4'b0000;
    // replicating the data puts it on every lane it could land on; the mask picks the real ones
    wword = digit == DIGIT_B ? {4{wdata[7:0]}} :
            digit == DIGIT_H ? {2{wdata[15:0]}} : wdata;
    keep = digit == DIGIT_B ? 32'h0000_00ff :
           digit == DIGIT_H ? 32'h0000_ffff :
           digit == DIGIT_W ? 32'hffff_ffff : 32'h0;
    rdata = sh & keep;
    misalign = (digit == DIGIT_H && lane[0]) || (digit == DIGIT_W && lane != 2'b00);
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed wait states and byte-lane storage
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_digit,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic q_we;
  logic [1:0] q_digit;
  logic [31:0] q_addr, q_wdata;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, commit, err, misalign, c_we;
  logic [1:0] c_digit;
  logic [31:0] c_addr, c_wdata, wword, rdata, rword;
  logic [3:0] mask;
  logic [AW-1:0] widx;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept = req_valid & req_ready;
  // with zero wait states the commit edge is the accept edge, so the live request is used
  assign c_we = state == IDLE ? req_we : q_we;
  assign c_digit = state == IDLE ? req_digit : q_digit;
  assign c_addr = state == IDLE ? req_addr : q_addr;
  assign c_wdata = state == IDLE ? req_wdata : q_wdata;
  assign widx = c_addr[AW+1:2];
  assign rword = mem[widx];
  assign err = misalign || c_digit == 2'b11 || c_addr[31:2] >= 30'(DEPTH_WORDS);
  assign commit = !Reset && (state == IDLE ? accept && WAIT_CYCLES == 0 : state == WAIT && cnt == 0);
  dmem_lane_align u_align (
    .digit(c_digit),
    .lane(c_addr[1:0]),
    .wdata(c_wdata),
    .rword(rword),
    .mask(mask),
    .wword(wword),
    .rdata(rdata),
    .misalign(misalign)
  );
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
      WAIT: if (cnt == 0) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      q_we <= 1'b0;
      q_digit <= '0;
      q_addr <= '0;
      q_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        q_we <= req_we;
        q_digit <= req_digit;
        q_addr <= req_addr;
        q_wdata <= req_wdata;
      end
      cnt <= accept ? CNT_INIT : (state == WAIT && cnt != 0) ? cnt - 1'b1 : cnt;
      if (commit) begin
        resp_rdata <= (err || c_we) ? '0 : rdata;
        resp_err <= err;
      end else if (state == RESP) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
    end
  // storage is deliberately left out of reset so committed data survives it
  always_ff @(posedge CLK)
    for (int i = 0; i < 4; i++)
      if (commit && c_we && !err && mask[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: byte-array reference model with per-cycle output comparison plus directed literal checks
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int WC = 2;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_we = 0;
  logic [1:0] req_digit = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic v1 = 0, we1 = 0;
  logic [1:0] dg1 = 0;
  logic [31:0] ad1 = 0, wd1 = 0;
  logic rdy1, rv1, re1;
  logic [31:0] rd1;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .CLK(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_digit(req_digit), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .Reset(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_digit(dg1), .req_addr(ad1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // reference model: a flat byte array and a single pending transaction with its commit edge
  logic [7:0] ref_b [4*DEPTH];
  int cyc = 0, next_free = 0, pend_edge = 0, accepts = 0, pulses = 0, n;
  bit pend = 0, model_ready = 1, exp_v = 0;
  logic p_we, exp_err;
  logic [1:0] p_dg;
  logic [31:0] p_ad, p_wd, exp_rd;
  initial for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      pend = 0;
      next_free = 0;
    end else if (req_valid && model_ready) begin
      accepts++;
      p_we = req_we; p_dg = req_digit; p_ad = req_addr; p_wd = req_wdata;
      pend = 1;
      pend_edge = cyc + 1 + WC;
      next_free = cyc + 2 + WC;
    end
    cyc++;
    exp_v = 0;
    if (pend && pend_edge == cyc) begin
      n = p_dg == 2'd0 ? 1 : p_dg == 2'd1 ? 2 : 4;
      exp_err = p_dg == 2'd3 || (p_ad % n) != 0 || p_ad >= 4*DEPTH;
      exp_rd = 0;
      if (!exp_err)
        for (int i = 0; i < n; i++)
          if (p_we) ref_b[p_ad+i] = p_wd[8*i +: 8];
          else exp_rd = exp_rd | (32'(ref_b[p_ad+i]) << (8*i));
      pend = 0;
      exp_v = 1;
    end
    model_ready = rst || cyc >= next_free;
  end
  always @(negedge clk) begin
    chk("ready", req_ready, model_ready);
    chk("resp_valid", resp_valid, exp_v);
    chk("resp_rdata", resp_rdata, exp_v ? exp_rd : 32'h0);
    chk("resp_err", resp_err, exp_v ? exp_err : 1'b0);
    if (resp_valid) pulses++;
  end
  task automatic xfer(input logic we, input logic [1:0] dg, input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int low);
    bit got;
    got = 0; low = 0; rd = 0; er = 0;
    @(negedge clk); #1;
    req_we = we; req_digit = dg; req_addr = ad; req_wdata = wd; req_valid = 1;
    for (int i = 0; i < 20 && !req_ready; i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    req_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (!req_ready) low++;
      if (resp_valid) begin got = 1; rd = resp_rdata; er = resp_err; break; end
      @(negedge clk); #1;
    end
    chk("resp_seen", got, 1);
  endtask
  logic [31:0] rd;
  logic er;
  int low, a0, p0;
  bit r;
  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    rst = 0;
    xfer(1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, low);
    chk("st_err", er, 0); chk("st_rdata", rd, 0); chk("st_busy", low, 3);
    xfer(0, 2'b10, 32'h10, 0, rd, er, low);
    chk("ld_w", rd, 32'hDEADBEEF); chk("ld_w_err", er, 0); chk("ld_busy", low, 3);
    xfer(1, 2'b00, 32'h11, 32'h0000005A, rd, er, low);
    chk("stb_err", er, 0);
    xfer(0, 2'b10, 32'h10, 0, rd, er, low);
    chk("ld_w_merged", rd, 32'hDEAD5AEF);
    xfer(0, 2'b01, 32'h12, 0, rd, er, low);
    chk("ld_h", rd, 32'h0000DEAD); chk("ld_h_err", er, 0);
    xfer(0, 2'b00, 32'h13, 0, rd, er, low);
    chk("ld_b", rd, 32'h000000DE);
    xfer(0, 2'b01, 32'h11, 0, rd, er, low);
    chk("err_h_rdata", rd, 0); chk("err_h", er, 1);
    xfer(0, 2'b10, 32'h12, 0, rd, er, low);
    chk("err_w_rdata", rd, 0); chk("err_w", er, 1);
    xfer(0, 2'b11, 32'h10, 0, rd, er, low);
    chk("err_dig_rdata", rd, 0); chk("err_dig", er, 1);
    xfer(0, 2'b10, 32'h400, 0, rd, er, low);
    chk("err_rng_rdata", rd, 0); chk("err_rng", er, 1);
    xfer(1, 2'b10, 32'h12, 32'h11111111, rd, er, low);
    chk("err_st", er, 1);
    xfer(0, 2'b10, 32'h10, 0, rd, er, low);
    chk("after_err", rd, 32'hDEAD5AEF); chk("after_err_err", er, 0);
    // continuous valid: requests alternate after every accept
    a0 = accepts; p0 = pulses;
    @(negedge clk); #1;
    req_we = 0; req_digit = 2'b10; req_addr = 32'h10; req_valid = 1;
    for (int i = 0; i < 16; i++) begin
      r = req_ready;
      @(negedge clk); #1;
      if (r) begin
        if (req_digit == 2'b10) begin req_digit = 2'b01; req_addr = 32'h12; end
        else begin req_digit = 2'b10; req_addr = 32'h10; end
      end
    end
    req_valid = 0;
    repeat (6) @(negedge clk);
    chk("burst_accepts", accepts - a0, 4);
    chk("burst_pulses", pulses - p0, 4);
    // reset during the wait states of a store
    xfer(1, 2'b10, 32'h20, 32'h0, rd, er, low);
    chk("pre_err", er, 0);
    @(negedge clk); #1;
    req_we = 1; req_digit = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1;
    @(negedge clk); #1;
    req_valid = 0; rst = 1;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rdata", resp_rdata, 0);
    chk("mid_rst_err", resp_err, 0);
    p0 = pulses;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_resp", pulses - p0, 0);
    xfer(0, 2'b10, 32'h20, 0, rd, er, low);
    chk("rst_dropped", rd, 32'h0); chk("rst_dropped_err", er, 0);
    // zero-wait-state instance: store then back-to-back load
    @(negedge clk); #1;
    v1 = 1; we1 = 1; dg1 = 2'b10; ad1 = 32'h40; wd1 = 32'hCAFEF00D;
    chk("w0_idle_ready", rdy1, 1);
    @(negedge clk); #1;
    chk("w0_st_valid", rv1, 1); chk("w0_st_err", re1, 0); chk("w0_busy", rdy1, 0);
    we1 = 0;
    @(negedge clk); #1;
    chk("w0_gap_valid", rv1, 0); chk("w0_gap_ready", rdy1, 1);
    @(negedge clk); #1;
    chk("w0_ld_valid", rv1, 1); chk("w0_ld_rdata", rd1, 32'hCAFEF00D); chk("w0_ld_err", re1, 0);
    v1 = 0;
    @(negedge clk); #1;
    chk("w0_done", rv1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
